// File: rtl/he_pkg.sv
// Shared types for the homomorphic-operation sequencer: opcodes, opcode-register
// field layout and sequencer states.
package he_pkg;

  typedef enum logic [1:0] {
    OpNop  = 2'b00,
    OpCopy = 2'b01,
    OpAdd  = 2'b10,
    OpSub  = 2'b11
  } op_e;

  // Field positions inside the 32-bit Wishbone opcode register.
  localparam int unsigned OpLsb   = 0;
  localparam int unsigned OpMsb   = 1;
  localparam int unsigned SrcALsb = 2;
  localparam int unsigned SrcAMsb = 11;
  localparam int unsigned SrcBLsb = 12;
  localparam int unsigned SrcBMsb = 21;
  localparam int unsigned DstLsb  = 22;
  localparam int unsigned DstMsb  = 31;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StCalc,
    StWr,
    StDone
  } state_e;

endpackage

// File: rtl/he_op_sequencer_if.sv
// Command, host and scratch-memory signals of the sequencer, grouped as one bundle.
interface he_op_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 128
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [1:0]            cmd_op_i;
  logic [ADDR_WIDTH-1:0] cmd_src_a_i;
  logic [ADDR_WIDTH-1:0] cmd_src_b_i;
  logic [ADDR_WIDTH-1:0] cmd_dst_i;

  logic                  host_req_i;
  logic                  host_we_i;
  logic [ADDR_WIDTH-1:0] host_addr_i;
  logic [DATA_WIDTH-1:0] host_wdata_i;
  logic                  host_gnt_o;

  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_src_a_i, cmd_src_b_i, cmd_dst_i,
    output host_req_i, host_we_i, host_addr_i, host_wdata_i, mem_rdata_i,
    input  cmd_ready_o, host_gnt_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_src_a_i, cmd_src_b_i, cmd_dst_i,
    input  host_req_i, host_we_i, host_addr_i, host_wdata_i, mem_rdata_i,
    output cmd_ready_o, host_gnt_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/he_elem_alu.sv
// Element-wise modular add/sub/copy; the modulus is 2^CIPHERTEXT_WIDTH, so
// plain truncating arithmetic is the reduction.
module he_elem_alu
  import he_pkg::*;
#(
  parameter int unsigned CIPHERTEXT_WIDTH = 10
) (
  input  op_e                         op_i,
  input  logic [CIPHERTEXT_WIDTH-1:0] a_i,
  input  logic [CIPHERTEXT_WIDTH-1:0] b_i,
  output logic [CIPHERTEXT_WIDTH-1:0] res_o
);

  always_comb begin
    res_o = a_i;
    unique case (op_i)
      OpAdd:   res_o = a_i + b_i;
      OpSub:   res_o = a_i - b_i;
      default: res_o = a_i;
    endcase
  end

endmodule

// File: rtl/he_op_sequencer.sv
// Walks the DIMENSION+1 ciphertext elements through the shared scratch memory and
// arbitrates that single port between the engine and host accesses.
module he_op_sequencer
  import he_pkg::*;
#(
  parameter int unsigned CIPHERTEXT_WIDTH = 10,
  parameter int unsigned DIMENSION        = 2,
  parameter int unsigned DATA_WIDTH       = 128,
  parameter int unsigned ADDR_WIDTH       = 10
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  he_op_sequencer_if.slave   bus,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned IdxWidth = (DIMENSION > 0) ? $clog2(DIMENSION + 1) : 1;

  state_e                      state_q, state_d;
  op_e                         op_q, op_d;
  logic [ADDR_WIDTH-1:0]       src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
  logic [IdxWidth-1:0]         idx_q, idx_d;
  logic [CIPHERTEXT_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CIPHERTEXT_WIDTH-1:0] res;
  logic [ADDR_WIDTH-1:0]       idx_ext;

  logic                  eng_en, eng_we, host_slot;
  logic [ADDR_WIDTH-1:0] eng_addr;
  logic [DATA_WIDTH-1:0] eng_wdata;

  assign idx_ext = ADDR_WIDTH'(idx_q);

  he_elem_alu #(
    .CIPHERTEXT_WIDTH(CIPHERTEXT_WIDTH)
  ) u_alu (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .res_o (res)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      dst_q   <= dst_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    dst_d     = dst_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    eng_en    = 1'b0;
    eng_we    = 1'b0;
    eng_addr  = '0;
    eng_wdata = '0;
    host_slot = 1'b0;
    busy_o    = 1'b1;
    done_o    = 1'b0;
    bus.cmd_ready_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy_o          = 1'b0;
        host_slot       = 1'b1;
        bus.cmd_ready_o = 1'b1;
        if (bus.cmd_valid_i) begin
          op_d    = op_e'(bus.cmd_op_i);
          src_a_d = bus.cmd_src_a_i;
          src_b_d = bus.cmd_src_b_i;
          dst_d   = bus.cmd_dst_i;
          idx_d   = '0;
          state_d = (op_e'(bus.cmd_op_i) == OpNop) ? StDone : StRdA;
        end
      end
      StRdA: begin
        eng_en   = 1'b1;
        eng_addr = src_a_q + idx_ext;
        state_d  = StRdB;
      end
      StRdB: begin
        a_d = bus.mem_rdata_i[CIPHERTEXT_WIDTH-1:0];
        if (op_q != OpCopy) begin
          eng_en   = 1'b1;
          eng_addr = src_b_q + idx_ext;
        end
        state_d = StCalc;
      end
      StCalc: begin
        // Port is free this cycle; a host read here returns during WR, which ignores rdata.
        host_slot = 1'b1;
        if (op_q != OpCopy) b_d = bus.mem_rdata_i[CIPHERTEXT_WIDTH-1:0];
        state_d = StWr;
      end
      StWr: begin
        eng_en    = 1'b1;
        eng_we    = 1'b1;
        eng_addr  = dst_q + idx_ext;
        eng_wdata = DATA_WIDTH'(res);
        if (idx_q == IdxWidth'(DIMENSION)) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IdxWidth'(1);
          state_d = StRdA;
        end
      end
      StDone: begin
        done_o    = 1'b1;
        host_slot = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.host_gnt_o = bus.host_req_i && host_slot;
    if (bus.host_gnt_o) begin
      bus.mem_en_o    = 1'b1;
      bus.mem_we_o    = bus.host_we_i;
      bus.mem_addr_o  = bus.host_addr_i;
      bus.mem_wdata_o = bus.host_wdata_i;
    end else begin
      bus.mem_en_o    = eng_en;
      bus.mem_we_o    = eng_we;
      bus.mem_addr_o  = eng_addr;
      bus.mem_wdata_o = eng_wdata;
    end
  end

endmodule

// File: tb/tb_he_op_sequencer.sv
// Directed bench for he_op_sequencer: a per-cycle reference model of the command
// timing and memory contents, plus literal expectations for each scenario.
module tb_he_op_sequencer;

  localparam int unsigned CW  = 10;
  localparam int unsigned DIM = 2;
  localparam int unsigned DW  = 128;
  localparam int unsigned AW  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done;

  he_op_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  he_op_sequencer #(
    .CIPHERTEXT_WIDTH(CW),
    .DIMENSION       (DIM),
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst_n),
    .bus     (bus),
    .busy_o  (busy),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  // Single-port scratch memory with one-cycle read latency.
  logic [DW-1:0] mem [1024] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
      else              bus.mem_rdata_i     <= mem[bus.mem_addr_o];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  // Reference model state.
  logic [DW-1:0] ref_mem [1024] = '{default: '0};
  bit            active = 1'b0;
  int            c = 0;
  int            last_c = 0;
  logic [1:0]    m_op;
  logic [AW-1:0] m_a, m_b, m_d;
  bit            pend_valid = 1'b0;
  logic [DW-1:0] pend_data;

  initial begin
    forever begin
      @(negedge clk);
      begin
        bit            idle, is_done, slot, exp_gnt, exp_en, exp_we;
        int            k, ph;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wd, wa, wb;
        logic [CW-1:0] a10, b10, r10;

        if (!rst_n) active = 1'b0;
        idle    = !active;
        is_done = active && (c == last_c);
        ph      = (c - 1) % 4;
        k       = (c - 1) / 4;
        slot    = idle || is_done || (active && ph == 2);
        exp_gnt = bus.host_req_i && slot;
        exp_en  = 1'b0;
        exp_we  = 1'b0;
        exp_addr = '0;
        exp_wd  = '0;
        r10     = '0;

        if (exp_gnt) begin
          exp_en   = 1'b1;
          exp_we   = bus.host_we_i;
          exp_addr = bus.host_addr_i;
          exp_wd   = bus.host_wdata_i;
        end else if (active && !is_done) begin
          if (ph == 0) begin
            exp_en = 1'b1; exp_addr = AW'(m_a + k);
          end else if (ph == 1 && m_op != 2'b01) begin
            exp_en = 1'b1; exp_addr = AW'(m_b + k);
          end else if (ph == 3) begin
            wa  = ref_mem[AW'(m_a + k)];
            wb  = ref_mem[AW'(m_b + k)];
            a10 = wa[CW-1:0];
            b10 = wb[CW-1:0];
            r10 = (m_op == 2'b10) ? a10 + b10 : (m_op == 2'b11) ? a10 - b10 : a10;
            exp_en = 1'b1; exp_we = 1'b1; exp_addr = AW'(m_d + k); exp_wd = DW'(r10);
          end
        end

        chk("cmd_ready", DW'(bus.cmd_ready_o), DW'(idle));
        chk("busy", DW'(busy), DW'(!idle));
        chk("done", DW'(done), DW'(is_done));
        chk("host_gnt", DW'(bus.host_gnt_o), DW'(exp_gnt));
        chk("mem_en", DW'(bus.mem_en_o), DW'(exp_en));
        if (exp_en) begin
          chk("mem_we", DW'(bus.mem_we_o), DW'(exp_we));
          chk("mem_addr", DW'(bus.mem_addr_o), DW'(exp_addr));
          if (exp_we) chk("mem_wdata", bus.mem_wdata_o, exp_wd);
        end
        if (pend_valid) chk("host_rdata", bus.mem_rdata_i, pend_data);
        pend_valid = 1'b0;

        if (exp_gnt && !bus.host_we_i) begin
          pend_valid = 1'b1;
          pend_data  = ref_mem[bus.host_addr_i];
        end
        if (exp_en && exp_we) ref_mem[exp_addr] = exp_wd;

        if (rst_n) begin
          if (active) begin
            if (c == last_c) active = 1'b0;
            else c++;
          end else if (bus.cmd_valid_i) begin
            active = 1'b1;
            c      = 1;
            m_op   = bus.cmd_op_i;
            m_a    = bus.cmd_src_a_i;
            m_b    = bus.cmd_src_b_i;
            m_d    = bus.cmd_dst_i;
            last_c = (bus.cmd_op_i == 2'b00) ? 1 : 4 * (DIM + 1) + 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.host_req_i = 1'b1; bus.host_we_i = 1'b1; bus.host_addr_i = a; bus.host_wdata_i = d;
    tick();
    bus.host_req_i = 1'b0; bus.host_we_i = 1'b0;
  endtask

  task automatic host_read_chk(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bus.host_req_i = 1'b1; bus.host_we_i = 1'b0; bus.host_addr_i = a;
    tick();
    bus.host_req_i = 1'b0;
    @(negedge clk);
    chk(nm, bus.mem_rdata_i, exp);
    tick();
  endtask

  // Returns at accept edge + #1, i.e. inside cycle 1.
  task automatic start_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] d);
    bit ok = 1'b0;
    bus.cmd_valid_i = 1'b1; bus.cmd_op_i = op;
    bus.cmd_src_a_i = a; bus.cmd_src_b_i = b; bus.cmd_dst_i = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.cmd_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", DW'(ok), DW'(1));
      $display("FAIL accept_timeout: command never accepted");
      $fatal(1, "accept timeout");
    end
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_cycle);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk(nm, DW'(n), DW'(exp_cycle));
    tick();
  endtask

  initial begin
    logic [DW-1:0] hi;
    int grants;
    bit prev_gnt;
    bus.cmd_valid_i = 1'b0; bus.cmd_op_i = 2'b00;
    bus.cmd_src_a_i = '0; bus.cmd_src_b_i = '0; bus.cmd_dst_i = '0;
    bus.host_req_i = 1'b0; bus.host_we_i = 1'b0; bus.host_addr_i = '0; bus.host_wdata_i = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", DW'(bus.cmd_ready_o), DW'(1));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_mem_en", DW'(bus.mem_en_o), DW'(0));
    chk("rst_mem_addr", DW'(bus.mem_addr_o), DW'(0));
    chk("rst_mem_wdata", bus.mem_wdata_o, DW'(0));
    tick();
    rst_n = 1'b1;
    tick();

    host_write(10'd0, DW'(10));  host_write(10'd1, DW'(15));  host_write(10'd2, DW'(20));
    host_write(10'd100, DW'(20)); host_write(10'd101, DW'(25)); host_write(10'd102, DW'(30));

    // ADD, done in cycle 13
    start_cmd(2'b10, 10'd0, 10'd100, 10'd50);
    wait_done("add_done_cycle", 13);
    host_read_chk("add_w50", 10'd50, DW'(30));
    host_read_chk("add_w51", 10'd51, DW'(40));
    host_read_chk("add_w52", 10'd52, DW'(50));

    // SUB wraps modulo 1024
    start_cmd(2'b11, 10'd0, 10'd100, 10'd60);
    wait_done("sub_done_cycle", 13);
    host_read_chk("sub_w60", 10'd60, DW'(1014));
    host_read_chk("sub_w62", 10'd62, DW'(1014));

    // ADD overflow; upper word bits above CW are ignored
    hi = '0; hi[100] = 1'b1; hi[4:0] = 5'd5;
    host_write(10'd200, DW'(1000)); host_write(10'd300, DW'(30)); host_write(10'd201, hi);
    start_cmd(2'b10, 10'd200, 10'd300, 10'd400);
    wait_done("ovf_done_cycle", 13);
    host_read_chk("ovf_w400", 10'd400, DW'(6));
    host_read_chk("ovf_w401", 10'd401, DW'(5));

    // COPY with source address wrap
    host_write(10'd1023, DW'(7));
    start_cmd(2'b01, 10'd1023, 10'd500, 10'd700);
    wait_done("copy_done_cycle", 13);
    host_read_chk("copy_w700", 10'd700, DW'(7));
    host_read_chk("copy_w701", 10'd701, DW'(10));
    host_read_chk("copy_w702", 10'd702, DW'(15));

    // Host read held through an ADD: granted only in the CALC cycles
    start_cmd(2'b10, 10'd0, 10'd100, 10'd80);
    bus.host_req_i = 1'b1; bus.host_we_i = 1'b0; bus.host_addr_i = 10'd101;
    grants = 0; prev_gnt = 1'b0;
    for (int i = 1; i < 13; i++) begin
      @(negedge clk);
      if (prev_gnt) chk("held_rdata", bus.mem_rdata_i, DW'(25));
      prev_gnt = bus.host_gnt_o;
      if (bus.host_gnt_o) grants++;
    end
    @(negedge clk);
    chk("held_grants", DW'(grants), DW'(3));
    chk("held_done", DW'(done), DW'(1));
    tick();
    bus.host_req_i = 1'b0;
    tick();
    host_read_chk("held_w80", 10'd80, DW'(30));
    host_read_chk("held_w82", 10'd82, DW'(50));

    // Command held while busy, then a NOP
    start_cmd(2'b10, 10'd0, 10'd100, 10'd70);
    bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 2'b00;
    wait_done("busy_done_cycle", 13);
    @(negedge clk);
    chk("ready_after_done", DW'(bus.cmd_ready_o), DW'(1));
    tick();
    bus.cmd_valid_i = 1'b0;
    wait_done("nop_done_cycle", 1);

    // Reset during cycle 6 of an ADD
    host_write(10'd91, DW'(777)); host_write(10'd92, DW'(777));
    start_cmd(2'b10, 10'd0, 10'd100, 10'd90);
    repeat (5) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", DW'(busy), DW'(0));
    chk("mid_rst_mem_en", DW'(bus.mem_en_o), DW'(0));
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    host_read_chk("rst_w90", 10'd90, DW'(30));
    host_read_chk("rst_w91", 10'd91, DW'(777));
    host_read_chk("rst_w92", 10'd92, DW'(777));

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
